subtrator_serial: RTL and testbench

Bit-serial unsigned subtractor, the inverse operation of the team's 4-bit combinational adder. It computes res = a - b one bit per clock, LSB first, under a start/busy/done handshake. It also flags borrow (a < b). It sits beside the adder in the arithmetic datapath exercises and reuses the same operand widths.

---
 rtl/somador_pkg.sv | 15 +
 rtl/subtrator_serial_if.sv | 30 +++
 rtl/subtrator_1bit.sv | 20 ++
 rtl/subtrator_serial.sv | 111 +++++++++++
 tb/tb_subtrator_serial.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/somador_pkg.sv
// Shared definitions for the arithmetic datapath exercises (adder / serial
// subtractor): default operand width and the serial subtractor state type.
package somador_pkg;

    // Default operand / result width shared with the 4-bit adder.
    localparam int DEF_WIDTH = 4;

    // Serial subtractor control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/subtrator_serial_if.sv
// Handshake/operand bundle for the bit-serial subtractor.
//   start  : request, sampled only while the subtractor is idle
//   a, b   : minuend / subtrahend, captured on an accepted start
//   res    : difference a - b mod 2^WIDTH, held until the next completion
//   borrow : 1 iff a < b (unsigned), held with res
//   busy   : high while an operation is in flight (CALC and DONE)
//   done   : one-cycle pulse when res/borrow are updated
interface subtrator_serial_if #(
    parameter int WIDTH = somador_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic             busy;
    logic             done;

    // Requester side: drives operands and start, observes results.
    modport master (
        output start, a, b,
        input  res, borrow, busy, done
    );

    // Subtractor side.
    modport slave (
        input  start, a, b,
        output res, borrow, busy, done
    );
endinterface

// File: rtl/subtrator_1bit.sv
// Combinational full subtractor: d = ai - bi - bin (one bit).
//   ai_i, bi_i : operand bits
//   bin_i      : borrow in from the less significant bit
//   d_o        : difference bit
//   bout_o     : borrow out to the next more significant bit
module subtrator_1bit (
    input  logic ai_i,
    input  logic bi_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    // Borrow is generated when ai < bi, or propagated when ai == bi.
    always_comb begin
        d_o    = ai_i ^ bi_i ^ bin_i;
        bout_o = (~ai_i & bi_i) | (~(ai_i ^ bi_i) & bin_i);
    end

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial unsigned subtractor: res = a - b, one bit per clock, LSB first,
// under a start/busy/done handshake.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : subtrator_serial_if slave modport (start, a, b, res, borrow,
//           busy, done)
module subtrator_serial
    import somador_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    subtrator_serial_if.slave    bus
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    sub_state_t       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sh_q;
    logic [IDX_W-1:0] idx_q;
    logic             bin_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

    logic             d_s;
    logic             bout_s;
    logic [WIDTH-1:0] sh_d;
    logic [IDX_W-1:0] idx_d;

    subtrator_1bit u_bit (
        .ai_i   (a_q[idx_q]),
        .bi_i   (b_q[idx_q]),
        .bin_i  (bin_q),
        .d_o    (d_s),
        .bout_o (bout_s)
    );

    // Next shift-register value (difference bit enters at the MSB so that
    // after WIDTH shifts bit 0 sits at the LSB) and next bit index.
    always_comb begin
        sh_d  = {d_s, sh_q[WIDTH-1:1]};
        idx_d = idx_q + IDX_W'(1);
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            idx_q    <= '0;
            bin_q    <= 1'b0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        idx_q   <= '0;
                        bin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    sh_q  <= sh_d;
                    bin_q <= bout_s;
                    if (idx_q == LAST_IDX) begin
                        // Publish only on completion; partial results stay internal.
                        res_q    <= sh_d;
                        borrow_q <= bout_s;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        idx_q    <= idx_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.res    = res_q;
    assign bus.borrow = borrow_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial (WIDTH=4): directed vector table,
// hand-written multi-cycle corner cases and an exhaustive 4-bit sweep.
module tb_subtrator_serial;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    subtrator_serial_if #(.WIDTH(W)) bus ();

    subtrator_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       bor;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full operation: start at a negedge, expect done WIDTH+1 cycles later.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] er, input logic eb, input string name);
        int cyc;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 20) begin
            chk({name, "_busy"}, int'(bus.busy), 1);
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, cyc, W + 1);
        chk({name, "_busy_done"}, int'(bus.busy), 1);
        chk({name, "_res"}, int'(bus.res), int'(er));
        chk({name, "_borrow"}, int'(bus.borrow), int'(eb));
        @(negedge clk);
        chk({name, "_done_clear"}, int'(bus.done), 0);
        chk({name, "_idle"}, int'(bus.busy), 0);
    endtask

    initial begin
        int last;
        int pulses;
        int cyc;
        n_checks  = 0;
        n_errors  = 0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;

        vecs[0] = '{a: 4'd5,  b: 4'd3,  res: 4'd2,  bor: 1'b0};
        vecs[1] = '{a: 4'd3,  b: 4'd5,  res: 4'hE,  bor: 1'b1};
        vecs[2] = '{a: 4'd0,  b: 4'd1,  res: 4'hF,  bor: 1'b1};
        vecs[3] = '{a: 4'hF,  b: 4'hF,  res: 4'h0,  bor: 1'b0};
        vecs[4] = '{a: 4'hF,  b: 4'h0,  res: 4'hF,  bor: 1'b0};
        vecs[5] = '{a: 4'h8,  b: 4'h9,  res: 4'hF,  bor: 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_res", int'(bus.res), 0);
        chk("rst_borrow", int'(bus.borrow), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].bor, $sformatf("vec%0d", i));
        end

        // start and operand changes while busy are ignored
        bus.a = 4'd9; bus.b = 4'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.a = 4'd1; bus.b = 4'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 2;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_latency", cyc, W + 1);
        chk("ign_res", int'(bus.res), 7);
        chk("ign_borrow", int'(bus.borrow), 0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        chk("ign_no_second_op", pulses, 0);
        chk("ign_res_held", int'(bus.res), 7);

        // Reset during CALC discards the partial result
        bus.a = 4'd8; bus.b = 4'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_res", int'(bus.res), 0);
        chk("mrst_borrow", int'(bus.borrow), 0);
        chk("mrst_busy", int'(bus.busy), 0);
        chk("mrst_done", int'(bus.done), 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        chk("mrst_no_done", pulses, 0);
        do_op(4'd8, 4'd1, 4'd7, 1'b0, "mrst_after");

        // Back-to-back with start held high
        bus.a = 4'd6; bus.b = 4'd2; bus.start = 1'b1;
        last = 0; pulses = 0; cyc = 0;
        while (pulses < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                if (pulses == 0) chk("b2b_first", cyc, W + 1);
                else             chk("b2b_period", cyc - last, W + 2);
                last = cyc;
                pulses++;
            end
            if (pulses > 0) chk("b2b_res", int'(bus.res), 4);
        end
        chk("b2b_pulses", pulses, 4);
        bus.start = 1'b0;
        repeat (W + 2) @(negedge clk);
        chk("b2b_idle", int'(bus.busy), 0);

        // Exhaustive sweep against an independent model
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                logic [3:0] ax;
                logic [3:0] by;
                logic [3:0] er;
                ax = 4'(x);
                by = 4'(y);
                er = 4'((x - y) & 15);
                bus.a = ax; bus.b = by; bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                cyc = 1;
                while (!bus.done && cyc < 20) begin
                    @(negedge clk);
                    cyc++;
                end
                chk($sformatf("sw_%0d_%0d_lat", x, y), cyc, W + 1);
                chk($sformatf("sw_%0d_%0d_res", x, y), int'(bus.res), int'(er));
                chk($sformatf("sw_%0d_%0d_bor", x, y), int'(bus.borrow), (x < y) ? 1 : 0);
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
